// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: control, mux and result signals of the scan sequencer.
// Latency: none, plain signal bundle.
// Backpressure: none; start is a one-shot request and results are simply presented.
// Ports: start/continuous/dwell/ch_mask/mux_out into the sequencer;
//        select1/select2/channel/busy/sample/frame_done out of it.
// Optional: with MUXSEQ_ABORT_EN defined an abort request line is added.
interface mux_scan_sequencer_if #(
    parameter int DWELL_W = 4
);
`ifdef MUXSEQ_ABORT_EN
    logic               abort;
`endif
    logic               start;
    logic               continuous;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         ch_mask;
    logic               mux_out;
    logic               select1;
    logic               select2;
    logic [1:0]         channel;
    logic               busy;
    logic [3:0]         sample;
    logic               frame_done;

    // Environment side: issues requests, models the mux, observes results.
    modport master (
`ifdef MUXSEQ_ABORT_EN
        output abort,
`endif
        output start, continuous, dwell, ch_mask, mux_out,
        input  select1, select2, channel, busy, sample, frame_done
    );

    // Sequencer side.
    modport slave (
`ifdef MUXSEQ_ABORT_EN
        input  abort,
`endif
        input  start, continuous, dwell, ch_mask, mux_out,
        output select1, select2, channel, busy, sample, frame_done
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives the 4:1 mux selects through the enabled channels and
//   captures mux_out at the end of each channel's dwell into a 4-bit frame.
// Latency: k enabled channels x D dwell cycles of scanning, then one DONE cycle with frame_done.
// Backpressure: none; start is honoured only in IDLE and dropped in SCAN/DONE.
// Ports: clk, reset (async, active-high); bus (slave modport of mux_scan_sequencer_if).
// Optional: define MUXSEQ_ABORT_EN to add bus.abort, which returns to IDLE on the next edge
//   without publishing a frame.
module mux_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mux_scan_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         channel_q, channel_nxt;
    logic [DWELL_W-1:0] counter_q, counter_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic [3:0]         mask_q, mask_nxt;
    logic [3:0]         shadow_q, shadow_nxt;
    logic [3:0]         sample_q, sample_nxt;

    logic               abort_in;
    logic               last_cycle;
    logic [DWELL_W-1:0] dwell_in_eff;
    logic               relatch;
    logic               has_next;
    logic [1:0]         next_ch;

`ifdef MUXSEQ_ABORT_EN
    assign abort_in = bus.abort;
`else
    assign abort_in = 1'b0;
`endif

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_set = 2'(i);
        end
    endfunction

    // A dwell of 0 would never satisfy counter==D-1 sensibly, so it is promoted to 1.
    assign dwell_in_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign last_cycle   = (counter_q == dwell_q - DWELL_W'(1));

    // Next higher enabled channel in the latched mask; scanning never wraps.
    // Descending loop so the lowest qualifying channel is the final assignment.
    always_comb begin
        has_next = 1'b0;
        next_ch  = channel_q;
        for (int i = 3; i >= 0; i--) begin
            if ((i > int'(channel_q)) && mask_q[i]) begin
                has_next = 1'b1;
                next_ch  = 2'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        channel_nxt = channel_q;
        counter_nxt = counter_q;
        dwell_nxt   = dwell_q;
        mask_nxt    = mask_q;
        shadow_nxt  = shadow_q;
        sample_nxt  = sample_q;
        relatch     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) relatch = 1'b1;
            end
            SCAN: begin
                if (abort_in) begin
                    state_nxt = IDLE;
                end else if (last_cycle) begin
                    shadow_nxt[channel_q] = bus.mux_out;
                    counter_nxt           = '0;
                    if (has_next) begin
                        channel_nxt = next_ch;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    counter_nxt = counter_q + DWELL_W'(1);
                end
            end
            DONE: begin
                if (abort_in) begin
                    state_nxt = IDLE;
                end else begin
                    // The frame is published on the sample output during DONE and
                    // retained in sample_q from here on.
                    sample_nxt = shadow_q;
                    if (bus.continuous) begin
                        relatch = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Shared by a start in IDLE and a continuous restart out of DONE.
        // An empty mask leaves (or keeps) the machine in IDLE.
        if (relatch) begin
            if (bus.ch_mask != 4'b0) begin
                mask_nxt    = bus.ch_mask;
                dwell_nxt   = dwell_in_eff;
                shadow_nxt  = 4'b0;
                channel_nxt = lowest_set(bus.ch_mask);
                counter_nxt = '0;
                state_nxt   = SCAN;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            channel_q <= 2'd0;
            counter_q <= '0;
            dwell_q   <= '0;
            mask_q    <= 4'b0;
            shadow_q  <= 4'b0;
            sample_q  <= 4'b0;
        end else begin
            state     <= state_nxt;
            channel_q <= channel_nxt;
            counter_q <= counter_nxt;
            dwell_q   <= dwell_nxt;
            mask_q    <= mask_nxt;
            shadow_q  <= shadow_nxt;
            sample_q  <= sample_nxt;
        end
    end

    // frame_done is decoded from state so an abort raised during DONE can still
    // suppress it and keep the previous frame visible on sample.
    assign bus.frame_done = (state == DONE) && !abort_in;
    assign bus.sample     = bus.frame_done ? shadow_q : sample_q;
    assign bus.busy       = (state != IDLE);
    assign bus.channel    = channel_q;
    assign bus.select1    = channel_q[0];
    assign bus.select2    = channel_q[1];
endmodule
